// File: rtl/param_ctrl.sv
// param_ctrl: parameter-fetch controller for the FAST/Gaussian pipeline.
//
// Polls word 0 of a small synchronous parameter SRAM for START. When START is
// seen it streams words 1..6 out of the SRAM, then presents image geometry and
// filter settings on its output registers and pulses new_trans. The START
// word is cleared in the same cycle. When the pipeline reports img_done, a
// DONE status (0x02) is written back to word 0 and polling resumes.
//
// Ports:
//   clk, n_rst         clock (rising edge), asynchronous active-low reset
//   addr_params        SRAM read address
//   ren_params         SRAM read enable
//   rdat_params        SRAM read data, valid the cycle after ren_params
//   addr_write_params  SRAM write address
//   wen_params         SRAM write enable
//   wdat_params        SRAM write data
//   new_trans          one-cycle pulse: parameters loaded, frame may start
//   img_done           pipeline finished current frame (pulse)
//   max_x, max_y       image width / height
//   kernel_size        Gaussian kernel size
//   sigma              Gaussian sigma
//
// NUM_PARAMS >= 8 and BIT_DEPTH >= 8 are assumed. clog2(X_MAX) and
// clog2(Y_MAX) must not exceed 2*BIT_DEPTH.

module param_ctrl #(
    parameter int NUM_PARAMS = 8,
    parameter int BIT_DEPTH  = 8,
    parameter int X_MAX      = 400,
    parameter int Y_MAX      = 400
) (
    input  logic                          clk,
    input  logic                          n_rst,
    output logic [$clog2(NUM_PARAMS)-1:0] addr_params,
    output logic                          ren_params,
    input  logic [BIT_DEPTH-1:0]          rdat_params,
    output logic [$clog2(NUM_PARAMS)-1:0] addr_write_params,
    output logic                          wen_params,
    output logic [BIT_DEPTH-1:0]          wdat_params,
    output logic                          new_trans,
    input  logic                          img_done,
    output logic [$clog2(X_MAX)-1:0]      max_x,
    output logic [$clog2(Y_MAX)-1:0]      max_y,
    output logic [7:0]                    kernel_size,
    output logic [2:0]                    sigma
);

    localparam int AW = $clog2(NUM_PARAMS);
    localparam int XW = $clog2(X_MAX);
    localparam int YW = $clog2(Y_MAX);

    typedef enum logic [2:0] {
        POLL    = 3'd0,
        CHECK   = 3'd1,
        LOAD    = 3'd2,
        ACK     = 3'd3,
        BUSY    = 3'd4,
        DONE_WR = 3'd5
    } state_t;

    state_t               state, state_nxt;
    logic                 started;     // low for the first cycle after reset so every output starts at 0
    logic [2:0]           idx;         // LOAD read index; 7 is the capture-only cycle for word 6
    logic [BIT_DEPTH-1:0] shadow [1:5]; // words 1..5 held until word 6 arrives

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= POLL;
            started <= 1'b0;
        end else begin
            state   <= state_nxt;
            started <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            POLL:    state_nxt = started ? CHECK : POLL;
            CHECK:   state_nxt = rdat_params[0] ? LOAD : POLL;
            LOAD:    state_nxt = (idx == 3'd7) ? ACK : LOAD;
            ACK:     state_nxt = BUSY;
            BUSY:    state_nxt = img_done ? DONE_WR : BUSY;
            DONE_WR: state_nxt = POLL;
            default: state_nxt = POLL;
        endcase
    end

    // ------------------------------------------------------------------
    // SRAM / handshake outputs (Moore)
    // ------------------------------------------------------------------
    always_comb begin
        addr_params       = '0;
        ren_params        = 1'b0;
        addr_write_params = '0;
        wen_params        = 1'b0;
        wdat_params       = '0;
        new_trans         = 1'b0;
        case (state)
            POLL: begin
                ren_params = started;
            end
            LOAD: begin
                // idx 1..6 issue reads; idx 7 only collects the last word
                if (idx != 3'd7) begin
                    ren_params  = 1'b1;
                    addr_params = AW'(idx);
                end
            end
            ACK: begin
                // clear START and any stale DONE in one write
                wen_params = 1'b1;
                new_trans  = 1'b1;
            end
            DONE_WR: begin
                wen_params  = 1'b1;
                wdat_params = BIT_DEPTH'(2);
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Load index, word capture and parameter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            idx         <= '0;
            shadow[1]   <= '0;
            shadow[2]   <= '0;
            shadow[3]   <= '0;
            shadow[4]   <= '0;
            shadow[5]   <= '0;
            max_x       <= '0;
            max_y       <= '0;
            kernel_size <= '0;
            sigma       <= '0;
        end else begin
            if (state == CHECK) begin
                idx <= 3'd1;
            end else if (state == LOAD) begin
                idx <= idx + 3'd1;
                // rdat_params holds the word addressed in the previous cycle
                case (idx)
                    3'd2: shadow[1] <= rdat_params;
                    3'd3: shadow[2] <= rdat_params;
                    3'd4: shadow[3] <= rdat_params;
                    3'd5: shadow[4] <= rdat_params;
                    3'd6: shadow[5] <= rdat_params;
                    3'd7: begin
                        // all outputs switch together as ACK is entered
                        max_x       <= XW'({shadow[2], shadow[1]});
                        max_y       <= YW'({shadow[4], shadow[3]});
                        kernel_size <= 8'(shadow[5]);
                        sigma       <= rdat_params[2:0];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_param_ctrl.sv
// Self-checking bench for param_ctrl: SRAM model with a back-door write
// port, scoreboard queues for expected SRAM writes and parameter loads,
// and a negedge monitor that pops and compares whenever the DUT acts.

module tb_param_ctrl;

    localparam int NP = 8;
    localparam int BD = 8;
    localparam int AW = 3;
    localparam int XW = 9;
    localparam int YW = 9;

    logic          clk = 1'b0;
    logic          n_rst;
    logic [AW-1:0] addr_params;
    logic          ren_params;
    logic [BD-1:0] rdat_params;
    logic [AW-1:0] addr_write_params;
    logic          wen_params;
    logic [BD-1:0] wdat_params;
    logic          new_trans;
    logic          img_done;
    logic [XW-1:0] max_x;
    logic [YW-1:0] max_y;
    logic [7:0]    kernel_size;
    logic [2:0]    sigma;

    param_ctrl #(.NUM_PARAMS(NP), .BIT_DEPTH(BD), .X_MAX(400), .Y_MAX(400)) dut (
        .clk(clk), .n_rst(n_rst),
        .addr_params(addr_params), .ren_params(ren_params), .rdat_params(rdat_params),
        .addr_write_params(addr_write_params), .wen_params(wen_params), .wdat_params(wdat_params),
        .new_trans(new_trans), .img_done(img_done),
        .max_x(max_x), .max_y(max_y), .kernel_size(kernel_size), .sigma(sigma)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: one-cycle synchronous read, independent write port,
    // plus a back-door write port used by the bench while the DUT is idle.
    logic [BD-1:0] mem [NP];
    logic          bk_we;
    logic [AW-1:0] bk_addr;
    logic [BD-1:0] bk_dat;
    always @(posedge clk) begin
        if (ren_params) rdat_params <= mem[addr_params];
        if (wen_params) mem[addr_write_params] <= wdat_params;
        if (bk_we) mem[bk_addr] <= bk_dat;
    end

    typedef struct packed {
        logic [XW-1:0] mx;
        logic [YW-1:0] my;
        logic [7:0]    ks;
        logic [2:0]    sg;
    } ld_t;

    ld_t           exp_ld [$];
    logic [10:0]   exp_wr [$];   // {addr, data}
    ld_t           e_ld;
    logic [10:0]   e_wr;

    int n_chk  = 0;
    int n_fail = 0;
    int poll_cyc = -100;
    int done_cyc = -100;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({addr_params, ren_params, addr_write_params, wen_params, wdat_params,
                    new_trans, max_x, max_y, kernel_size, sigma});
    endfunction

    // Monitor: every write and every new_trans must match the scoreboard.
    always @(negedge clk) begin
        if (ren_params && addr_params == 3'd0) poll_cyc = cyc;
        if (wen_params) begin
            check("excl", 64'(ren_params), 64'd0);
            if (exp_wr.size() == 0) begin
                check("unexp_wr", 64'(wen_params), 64'd0);
            end else begin
                e_wr = exp_wr.pop_front();
                check("wr", 64'({addr_write_params, wdat_params}), 64'(e_wr));
                if (e_wr[7:0] == 8'h02) check("done_lat", 64'(cyc - done_cyc), 64'd1);
            end
        end
        if (new_trans) begin
            if (exp_ld.size() == 0) begin
                check("unexp_ld", 64'(new_trans), 64'd0);
            end else begin
                e_ld = exp_ld.pop_front();
                check("ld_lat", 64'(cyc - poll_cyc), 64'd9);
                check("ld_mx", 64'(max_x), 64'(e_ld.mx));
                check("ld_my", 64'(max_y), 64'(e_ld.my));
                check("ld_ks", 64'(kernel_size), 64'(e_ld.ks));
                check("ld_sg", 64'(sigma), 64'(e_ld.sg));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bk_write(input logic [AW-1:0] a, input logic [BD-1:0] d);
        bk_we = 1'b1; bk_addr = a; bk_dat = d;
        @(negedge clk);
        bk_we = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int k;
        k = 0;
        while ((exp_wr.size() + exp_ld.size()) != 0 && k < lim) begin
            @(negedge clk);
            k++;
        end
        if (k >= lim) check("timeout", 64'(exp_wr.size() + exp_ld.size()), 64'd0);
    endtask

    task automatic count_polls(input string tag);
        int rc;
        rc = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ren_params && addr_params == 3'd0) rc++;
        end
        check(tag, 64'(rc), 64'd4);
    endtask

    task automatic pulse_done();
        img_done = 1'b1;
        done_cyc = cyc;
        @(negedge clk);
        img_done = 1'b0;
    endtask

    task automatic check_params(input string tag, input ld_t e);
        check({tag, "_mx"}, 64'(max_x), 64'(e.mx));
        check({tag, "_my"}, 64'(max_y), 64'(e.my));
        check({tag, "_ks"}, 64'(kernel_size), 64'(e.ks));
        check({tag, "_sg"}, 64'(sigma), 64'(e.sg));
    endtask

    initial begin
        int k;
        n_rst = 1'b0; img_done = 1'b0;
        bk_we = 1'b0; bk_addr = '0; bk_dat = '0;
        @(negedge clk);
        for (int i = 0; i < NP; i++) bk_write(AW'(i), 8'h00);
        check("rst_out", all_outs(), 64'd0);

        // idle polling: one read of word 0 every second cycle
        n_rst = 1'b1;
        tick(2);
        count_polls("poll_cnt");

        // first load: 400 x 300, kernel 5, sigma 2
        bk_write(3'd1, 8'h90); bk_write(3'd2, 8'h01);
        bk_write(3'd3, 8'h2C); bk_write(3'd4, 8'h01);
        bk_write(3'd5, 8'h05); bk_write(3'd6, 8'h02);
        exp_ld.push_back('{mx: 9'd400, my: 9'd300, ks: 8'd5, sg: 3'd2});
        exp_wr.push_back({3'd0, 8'h00});
        bk_write(3'd0, 8'h01);
        wait_idle(40);
        tick(2);
        check("w0_clr", 64'(mem[0]), 64'h00);
        check_params("hold1", '{mx: 9'd400, my: 9'd300, ks: 8'd5, sg: 3'd2});

        // frame done -> DONE write next cycle, then polling again
        exp_wr.push_back({3'd0, 8'h02});
        pulse_done();
        wait_idle(10);
        tick(2);
        check("w0_done", 64'(mem[0]), 64'h02);
        count_polls("poll_after_done");

        // img_done while polling is ignored
        pulse_done();
        tick(10);
        check("w0_spur", 64'(mem[0]), 64'h02);
        check_params("spur", '{mx: 9'd400, my: 9'd300, ks: 8'd5, sg: 3'd2});

        // restart with new filter settings; sigma takes only bits [2:0]
        bk_write(3'd6, 8'hFF); bk_write(3'd5, 8'h07);
        exp_ld.push_back('{mx: 9'd400, my: 9'd300, ks: 8'd7, sg: 3'd7});
        exp_wr.push_back({3'd0, 8'h00});
        bk_write(3'd0, 8'h01);
        wait_idle(40);
        tick(2);
        check("w0_clr2", 64'(mem[0]), 64'h00);
        check_params("hold2", '{mx: 9'd400, my: 9'd300, ks: 8'd7, sg: 3'd7});

        // back to polling, then reset in the middle of a load
        exp_wr.push_back({3'd0, 8'h02});
        pulse_done();
        wait_idle(10);
        tick(2);
        bk_write(3'd0, 8'h01);
        k = 0;
        while (!(ren_params && addr_params == 3'd3) && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("load_seen", 64'(k < 20), 64'd1);
        n_rst = 1'b0;
        #1;
        check("midrst_out", all_outs(), 64'd0);
        tick(3);
        check("start_kept", 64'(mem[0]), 64'h01);
        exp_ld.push_back('{mx: 9'd400, my: 9'd300, ks: 8'd7, sg: 3'd7});
        exp_wr.push_back({3'd0, 8'h00});
        n_rst = 1'b1;
        wait_idle(40);
        tick(2);
        check("w0_clr3", 64'(mem[0]), 64'h00);
        check_params("hold3", '{mx: 9'd400, my: 9'd300, ks: 8'd7, sg: 3'd7});
        tick(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
